// File: rtl/skew_feeder.sv
// skew_feeder: ping-pong tile buffer that streams an A tile into a systolic
// array, either skewed (lane i delayed by i beats) or aligned.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. valid/data are held by the producer until the transfer; ready
// may toggle freely. Outputs here are registered and stay frozen while
// out_valid && !out_ready.
module skew_feeder #(
  parameter int ARRAY_SIZE = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_K      = 16
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       wr_valid,
  output logic                                       wr_ready,
  input  logic signed [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] wr_data,
  input  logic                                       wr_last,
  input  logic                                       skew_en,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic signed [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] out_data,
  output logic [ARRAY_SIZE-1:0]                      out_lane_valid,
  output logic                                       out_last
);

  // Column index, stored tile length and beat index widths.
  localparam int CW = (MAX_K > 1) ? $clog2(MAX_K) : 1;
  localparam int KW = $clog2(MAX_K + 1);
  localparam int TW = $clog2(MAX_K + ARRAY_SIZE);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_e;

  // Tile storage: [bank][lane][column].
  logic [DATA_WIDTH-1:0] mem [2][ARRAY_SIZE][MAX_K];

  bank_state_e     bank_state [2];
  logic [KW-1:0]   bank_k     [2];
  logic            bank_skew  [2];
  logic            wptr;
  logic            rptr;
  logic [CW-1:0]   wcnt;
  logic [TW-1:0]   tcnt;  // index of the next beat to load from rptr bank

  logic wr_fire;
  logic wr_close;
  logic rd_fire;
  logic rd_done;
  logic load_adv;    // next beat of the bank being drained
  logic load_switch; // beat 0 of the other bank, back-to-back after a last beat
  logic load_start;  // beat 0 of rptr bank from idle

  logic                                        sel_bank;
  logic [TW-1:0]                               sel_t;
  logic [TW-1:0]                               nbeats;
  logic [TW-1:0]                               col;
  logic signed [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] nxt_data;
  logic [ARRAY_SIZE-1:0]                       nxt_lane;
  logic                                        nxt_last;

  // A bank accepts columns until it is closed; reset blocks writes.
  assign wr_ready = !rst && (bank_state[wptr] == EMPTY || bank_state[wptr] == FILLING);
  assign wr_fire  = wr_valid && wr_ready;
  assign wr_close = wr_fire && (wr_last || wcnt == CW'(MAX_K - 1));
  assign rd_fire  = out_valid && out_ready;
  assign rd_done  = rd_fire && out_last;

  assign load_switch = rd_done && bank_state[!rptr] == FULL;
  assign load_adv    = rd_fire && !out_last;
  assign load_start  = !out_valid && bank_state[rptr] == FULL;

  assign sel_bank = load_switch ? !rptr : rptr;
  assign sel_t    = load_adv ? tcnt : '0;

  // Build the beat at index sel_t of bank sel_bank.
  always_comb begin
    nxt_data = '0;
    nxt_lane = '0;
    col      = '0;
    nbeats   = bank_skew[sel_bank] ? TW'(bank_k[sel_bank]) + TW'(ARRAY_SIZE - 1)
                                   : TW'(bank_k[sel_bank]);
    nxt_last = (sel_t == nbeats - TW'(1));
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      col = bank_skew[sel_bank] ? sel_t - TW'(i) : sel_t;
      if ((!bank_skew[sel_bank] || sel_t >= TW'(i)) && col < TW'(bank_k[sel_bank])) begin
        nxt_lane[i] = 1'b1;
        nxt_data[i] = mem[sel_bank][i][col[CW-1:0]];
      end
    end
  end

  // Column storage; contents are never cleared, only bank state is.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < ARRAY_SIZE; i++) begin
        mem[wptr][i][wcnt] <= wr_data[i];
      end
    end
  end

  // Bank state machines, pointers and the registered output beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_state[0]  <= EMPTY;
      bank_state[1]  <= EMPTY;
      bank_k[0]      <= '0;
      bank_k[1]      <= '0;
      bank_skew[0]   <= 1'b0;
      bank_skew[1]   <= 1'b0;
      wptr           <= 1'b0;
      rptr           <= 1'b0;
      wcnt           <= '0;
      tcnt           <= '0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_lane_valid <= '0;
      out_last       <= 1'b0;
    end else begin
      // Write side: the write bank is always EMPTY or FILLING here.
      if (wr_fire) begin
        if (bank_state[wptr] == EMPTY) begin
          bank_skew[wptr] <= skew_en;
        end
        if (wr_close) begin
          bank_state[wptr] <= FULL;
          bank_k[wptr]     <= KW'(wcnt) + KW'(1);
          wptr             <= !wptr;
          wcnt             <= '0;
        end else begin
          bank_state[wptr] <= FILLING;
          wcnt             <= wcnt + CW'(1);
        end
      end

      // Read side: the read bank is FULL or DRAINING, never the write bank.
      if (rd_done) begin
        bank_state[rptr] <= EMPTY;
        rptr             <= !rptr;
      end

      if (load_switch || load_adv || load_start) begin
        if (load_switch || load_start) begin
          bank_state[sel_bank] <= DRAINING;
        end
        out_valid      <= 1'b1;
        out_data       <= nxt_data;
        out_lane_valid <= nxt_lane;
        out_last       <= nxt_last;
        tcnt           <= sel_t + TW'(1);
      end else if (rd_done) begin
        out_valid      <= 1'b0;
        out_data       <= '0;
        out_lane_valid <= '0;
        out_last       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_skew_feeder.sv
// tb_skew_feeder: directed scenarios for skew_feeder at ARRAY_SIZE=4,
// MAX_K=16, with a scoreboard of expected output beats.
module tb_skew_feeder;

  localparam int ASZ = 4;
  localparam int DW  = 8;
  localparam int MK  = 16;
  localparam int BW  = ASZ * DW + ASZ + 1;  // {data, lane_valid, last}

  logic                     clk;
  logic                     rst;
  logic                     wr_valid;
  logic                     wr_ready;
  logic [ASZ-1:0][DW-1:0]   wr_data;
  logic                     wr_last;
  logic                     skew_en;
  logic                     out_valid;
  logic                     out_ready;
  logic [ASZ-1:0][DW-1:0]   out_data;
  logic [ASZ-1:0]           out_lane_valid;
  logic                     out_last;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [DW-1:0] tile_a [ASZ][MK];
  logic [BW-1:0] exp_q  [$];
  logic [BW-1:0] seen_q [$];
  int            seen_cyc [$];

  logic          prev_stall = 1'b0;
  logic [BW-1:0] prev_beat  = '0;

  skew_feeder #(.ARRAY_SIZE(ASZ), .DATA_WIDTH(DW), .MAX_K(MK)) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_data        (wr_data),
    .wr_last        (wr_last),
    .skew_en        (skew_en),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_lane_valid (out_lane_valid),
    .out_last       (out_last)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < ASZ; i++)
      for (int k = 0; k < MK; k++)
        tile_a[i][k] = DW'(10 * i + k);
  endtask

  task automatic fill_random();
    for (int i = 0; i < ASZ; i++)
      for (int k = 0; k < MK; k++)
        tile_a[i][k] = DW'($urandom_range(0, 255));
  endtask

  // Reference model: expected beats of a tile from tile_a.
  task automatic push_expected(input int k, input bit skew);
    int nb;
    int c;
    logic [ASZ-1:0][DW-1:0] d;
    logic [ASZ-1:0]         lv;
    nb = skew ? k + ASZ - 1 : k;
    for (int t = 0; t < nb; t++) begin
      d  = '0;
      lv = '0;
      for (int i = 0; i < ASZ; i++) begin
        c = skew ? t - i : t;
        if (c >= 0 && c < k) begin
          d[i]  = tile_a[i][c];
          lv[i] = 1'b1;
        end
      end
      exp_q.push_back({d, lv, (t == nb - 1)});
    end
  endtask

  // Driver: writes k columns; skew_en is inverted after column 0 so only
  // the first column's value matters.
  task automatic write_tile(input int k, input bit skew, input bit use_last);
    bit ok;
    int budget;
    push_expected(k, skew);
    for (int c = 0; c < k; c++) begin
      wr_valid = 1'b1;
      for (int i = 0; i < ASZ; i++) wr_data[i] = tile_a[i][c];
      wr_last  = use_last && (c == k - 1);
      skew_en  = (c == 0) ? skew : !skew;
      budget   = 0;
      do begin
        @(negedge clk);
        ok = wr_ready;
        @(posedge clk);
        #1;
        budget++;
      end while (!ok && budget < 300);
      check("wr_handshake", 64'(ok), 64'(1));
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    wr_data  = '0;
  endtask

  task automatic wait_drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 500) begin
      @(posedge clk);
      #1;
      budget++;
    end
    check("drain_done", 64'(exp_q.size()), 64'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_seen(input int n);
    int budget = 0;
    while (seen_q.size() < n && budget < 500) begin
      @(posedge clk);
      #1;
      budget++;
    end
    check("wait_seen", 64'(seen_q.size() >= n), 64'(1));
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [BW-1:0] cur;
    logic [BW-1:0] expb;
    cur = {out_data, out_lane_valid, out_last};
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("stall_hold", 64'({out_valid, cur}), 64'({1'b1, prev_beat}));
      if (!out_valid) begin
        check("idle_zero", 64'(cur), 64'(0));
      end else if (out_ready) begin
        check("beat_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          expb = exp_q.pop_front();
          check("beat", 64'(cur), 64'(expb));
        end
        seen_q.push_back(cur);
        seen_cyc.push_back(cyc);
      end
      prev_stall = out_valid && !out_ready;
      prev_beat  = cur;
    end
  end

  // Directed sequence.
  initial begin
    int sz;
    rst       = 1'b1;
    wr_valid  = 1'b0;
    wr_data   = '0;
    wr_last   = 1'b0;
    skew_en   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_ready", 64'(wr_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    rst = 1'b0;
    #1;
    check("post_rst_wr_ready", 64'(wr_ready), 64'(1));
    check("post_rst_outputs", 64'({out_valid, out_data, out_lane_valid, out_last}), 64'(0));

    // Skewed K=3 pattern tile.
    fill_pattern();
    seen_q.delete();
    write_tile(3, 1'b1, 1'b1);
    check("no_early_valid", 64'(out_valid), 64'(0));
    wait_drain();
    check("skew_beats", 64'(seen_q.size()), 64'(6));
    if (seen_q.size() == 6) begin
      check("skew_beat2_data", 64'(seen_q[2][BW-1:ASZ+1]), 64'(32'h00140B02));
      check("skew_beat2_lane", 64'(seen_q[2][ASZ:1]), 64'(4'b0111));
      check("skew_beat5_last", 64'(seen_q[5][0]), 64'(1));
      check("skew_beat4_last", 64'(seen_q[4][0]), 64'(0));
    end

    // Aligned K=3 pattern tile.
    seen_q.delete();
    write_tile(3, 1'b0, 1'b1);
    wait_drain();
    check("align_beats", 64'(seen_q.size()), 64'(3));
    if (seen_q.size() == 3) begin
      check("align_beat1_data", 64'(seen_q[1][BW-1:ASZ+1]), 64'(32'h1F150B01));
      check("align_beat1_lane", 64'(seen_q[1][ASZ:1]), 64'(4'b1111));
    end

    // Back-to-back tiles: no gap, writes blocked while both banks busy.
    seen_q.delete();
    seen_cyc.delete();
    fill_random();
    write_tile(3, 1'b1, 1'b1);
    fill_random();
    write_tile(3, 1'b1, 1'b1);
    check("wr_ready_both_busy", 64'(wr_ready), 64'(0));
    wait_drain();
    check("b2b_beats", 64'(seen_q.size()), 64'(12));
    if (seen_cyc.size() == 12)
      check("b2b_no_bubble", 64'(seen_cyc[6] - seen_cyc[5]), 64'(1));

    // Stall for 3 cycles mid-tile.
    seen_q.delete();
    fill_random();
    write_tile(5, 1'b1, 1'b1);
    wait_seen(2);
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain();
    check("stall_beats", 64'(seen_q.size()), 64'(8));

    // Forced last after MAX_K columns.
    seen_q.delete();
    fill_random();
    write_tile(16, 1'b1, 1'b0);
    wait_drain();
    check("forced_beats", 64'(seen_q.size()), 64'(19));
    if (seen_q.size() == 19)
      check("forced_last", 64'({seen_q[17][0], seen_q[18][0]}), 64'(2'b01));

    // Reset in the middle of a drain.
    seen_q.delete();
    fill_random();
    write_tile(8, 1'b1, 1'b1);
    wait_seen(3);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_wr_ready", 64'(wr_ready), 64'(1));
    sz = seen_q.size();
    repeat (5) @(posedge clk);
    #1;
    check("midrst_no_beats", 64'(seen_q.size()), 64'(sz));

    // Fresh aligned tile after reset.
    seen_q.delete();
    fill_random();
    write_tile(4, 1'b0, 1'b1);
    wait_drain();
    check("fresh_beats", 64'(seen_q.size()), 64'(4));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
